// File: rtl/ode_arith_pkg.sv
// Shared encodings for the ODE arithmetic arbiter: FSM states, op codes and fixed-point format.
package ode_arith_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    localparam int unsigned FRAC_BITS = 7;

endpackage

// File: rtl/arith_unit_arbiter_if.sv
// Requester and arithmetic-unit signal bundle for arith_unit_arbiter.
// master = the arbiter, slave = requesters plus multiplier/divider.
interface arith_unit_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned NUM_REQ   = 4
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ-1:0]           op_div;
    logic [NUM_REQ*WORD_SIZE-1:0] opa_flat;
    logic [NUM_REQ*WORD_SIZE-1:0] opb_flat;
    logic [NUM_REQ-1:0]           grant;
    logic [NUM_REQ-1:0]           done;
    logic [WORD_SIZE-1:0]         result;
    logic                         ovf;
    logic                         err;
    logic [WORD_SIZE-1:0]         unit_a;
    logic [WORD_SIZE-1:0]         unit_b;
    logic                         start_mul;
    logic                         start_div;
    logic [WORD_SIZE-1:0]         mul_result;
    logic                         mul_ovf;
    logic                         mul_done;
    logic [WORD_SIZE-1:0]         div_result;
    logic                         div_ovf;
    logic                         div_done;

    modport master (
        input  req, op_div, opa_flat, opb_flat,
        input  mul_result, mul_ovf, mul_done, div_result, div_ovf, div_done,
        output grant, done, result, ovf, err, unit_a, unit_b, start_mul, start_div
    );

    modport slave (
        output req, op_div, opa_flat, opb_flat,
        output mul_result, mul_ovf, mul_done, div_result, div_ovf, div_done,
        input  grant, done, result, ovf, err, unit_a, unit_b, start_mul, start_div
    );

endinterface

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping around.
module rr_priority_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         winner_o,
    output logic [$clog2(N)-1:0] id_o,
    output logic                 any_o
);
    localparam int unsigned IdW = $clog2(N);

    logic [IdW-1:0] idx;

    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        winner_o = '0;
        id_o     = '0;
        any_o    = 1'b0;
        idx      = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = IdW'((int'(ptr_i) + i) % int'(N));
            if (req_i[idx]) begin
                id_o  = idx;
                any_o = 1'b1;
            end
        end
        winner_o[id_o] = any_o;
    end

endmodule

// File: rtl/arith_unit_arbiter.sv
// Round-robin sharing of one multiplier and one divider among NUM_REQ requesters.
// Optional watchdog on unit completion enabled by defining ARB_TIMEOUT_EN.
module arith_unit_arbiter
    import ode_arith_pkg::*;
#(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic                  clk,
    input logic                  rst,
    arith_unit_arbiter_if.master bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 8-bit watchdog counter");
    end

    arb_state_e           state_q, state_d;
    op_e                  op_q, op_d;
    logic [IdW-1:0]       id_q, id_d, ptr_q, ptr_d;
    logic [WORD_SIZE-1:0] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic                 ovf_q, ovf_d;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
`endif

    logic [NUM_REQ-1:0] win_onehot, owner;
    logic [IdW-1:0]     win_id;
    logic               win_any, unit_done;

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (win_onehot),
        .id_o     (win_id),
        .any_o    (win_any)
    );

    // Only the unit that was started may complete the operation.
    assign unit_done = (op_q == OP_DIV) ? bus.div_done : bus.mul_done;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        ovf_d    = ovf_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    id_d    = win_id;
                    op_d    = (|(bus.op_div & win_onehot)) ? OP_DIV : OP_MUL;
                    opa_d   = bus.opa_flat[win_id*WORD_SIZE +: WORD_SIZE];
                    opb_d   = bus.opb_flat[win_id*WORD_SIZE +: WORD_SIZE];
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (unit_done) begin
                    result_d = (op_q == OP_DIV) ? bus.div_result : bus.mul_result;
                    ovf_d    = (op_q == OP_DIV) ? bus.div_ovf : bus.mul_ovf;
`ifdef ARB_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                    state_d  = ARB_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            ARB_RESP: begin
                ptr_d   = (id_q == IdW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            op_q     <= OP_MUL;
            id_q     <= '0;
            ptr_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            id_q     <= id_d;
            ptr_q    <= ptr_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        owner       = '0;
        owner[id_q] = 1'b1;
    end

    assign bus.grant     = (state_q != ARB_IDLE) ? owner : '0;
    assign bus.done      = (state_q == ARB_RESP) ? owner : '0;
    assign bus.start_mul = (state_q == ARB_ISSUE) && (op_q == OP_MUL);
    assign bus.start_div = (state_q == ARB_ISSUE) && (op_q == OP_DIV);
    assign bus.unit_a    = opa_q;
    assign bus.unit_b    = opb_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
